term_sequencer: RTL and testbench

Command sequencer between the UART receive stream, the two push buttons and the text-display `control` block of the serial terminal. It buffers received bytes in a small FIFO and echoes them to the UART transmitter. It arbitrates UART and button requests and maps control characters. It issues exactly one `putchar` or `clearhome` pulse at a time to `control`, and waits for each operation to complete before issuing the next.

---
 rtl/term_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_term_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_sequencer.sv
// term_sequencer: buffers UART RX bytes in a small FIFO, echoes them to UART TX,
// arbitrates RX bytes against the two push buttons and issues one putchar or
// clearhome operation at a time to the text-display control block.
module term_sequencer #(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] BTN_CHAR = 8'h41,
  parameter bit         ECHO     = 1'b1
) (
  input  logic                     CLK_12MHZ,
  input  logic                     rst,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic                     i_btn_put,
  input  logic                     i_btn_clear,
  input  logic                     i_busy,
  output logic                     o_putchar,
  output logic                     o_clearhome,
  output logic [7:0]               o_char,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT} state_t;
  typedef enum logic [1:0] {SRC_CLR, SRC_FIFO, SRC_PUT} src_t;
  typedef enum logic [1:0] {K_PUT, K_CLR, K_DROP} kind_t;

  // FIFO storage and pointers (one extra wrap bit distinguishes full from empty)
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_ptr_nxt, rd_ptr_nxt;
  logic        full, empty, push, pop;
  logic [7:0]  head;

  // Sequencer state and the request latched when leaving IDLE
  state_t      state, state_nxt;
  src_t        src, sel_src;
  kind_t       kind, sel_kind;
  logic [7:0]  sel_char;
  logic        sel_load;
  logic        pend_clr, pend_put;
  logic        clr_done, put_done;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Hold off RX while full, while an echo byte is still waiting (echo mode), and during reset
  assign s_axis_tready = !rst && !full && (!ECHO || !m_axis_tvalid);
  assign push          = s_axis_tvalid && s_axis_tready;

  assign wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;

  // FIFO data array write
  // NOTE: the storage array has no reset; the pointers alone say which entries are valid.
  always_ff @(posedge CLK_12MHZ) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
  end

  // FIFO pointers and registered occupancy
  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_12MHZ or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      o_level <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  // Echo register towards UART TX, independent of the sequencer
  always_ff @(posedge CLK_12MHZ or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'h00;
    end else if (ECHO && push) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Button request latches; issuing a request wins over a merged repeat pulse
  always_ff @(posedge CLK_12MHZ or posedge rst) begin
    if (rst) begin
      pend_clr <= 1'b0;
      pend_put <= 1'b0;
    end else begin
      pend_clr <= clr_done ? 1'b0 : (pend_clr | i_btn_clear);
      pend_put <= put_done ? 1'b0 : (pend_put | i_btn_put);
    end
  end

  // FSM state register
  always_ff @(posedge CLK_12MHZ or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Selected request; o_char only changes when leaving IDLE, so it is stable through WAIT
  always_ff @(posedge CLK_12MHZ or posedge rst) begin
    if (rst) begin
      src    <= SRC_CLR;
      kind   <= K_DROP;
      o_char <= 8'h00;
    end else if (sel_load) begin
      src    <= sel_src;
      kind   <= sel_kind;
      o_char <= sel_char;
    end
  end

  // Next state, request selection (mapping is resolved here and acted on in ISSUE) and pulses
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt   = state;
    sel_load    = 1'b0;
    sel_src     = SRC_CLR;
    sel_kind    = K_DROP;
    sel_char    = o_char;
    pop         = 1'b0;
    clr_done    = 1'b0;
    put_done    = 1'b0;
    o_putchar   = 1'b0;
    o_clearhome = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_clr) begin
          sel_load  = 1'b1;
          sel_src   = SRC_CLR;
          sel_kind  = K_CLR;
          state_nxt = S_ISSUE;
        end else if (!empty) begin
          sel_load  = 1'b1;
          sel_src   = SRC_FIFO;
          state_nxt = S_ISSUE;
          case (head)
            8'h0C:   sel_kind = K_CLR;
            8'h00:   sel_kind = K_DROP;
            8'h7F: begin
              sel_kind = K_PUT;
              sel_char = 8'h08;
            end
            default: begin
              sel_kind = K_PUT;
              sel_char = head;
            end
          endcase
        end else if (pend_put) begin
          sel_load  = 1'b1;
          sel_src   = SRC_PUT;
          sel_kind  = K_PUT;
          sel_char  = BTN_CHAR;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_putchar   = (kind == K_PUT);
        o_clearhome = (kind == K_CLR);
        pop         = (src == SRC_FIFO);
        clr_done    = (src == SRC_CLR);
        put_done    = (src == SRC_PUT);
        state_nxt   = (kind == K_DROP) ? S_IDLE : S_ARM;
      end
      S_ARM:   state_nxt = S_WAIT;
      S_WAIT:  if (!i_busy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_term_sequencer.sv
// tb_term_sequencer: directed, table-driven bench for term_sequencer (DEPTH=8,
// BTN_CHAR=0x41, ECHO=1). Pulses, echo bytes and RX acceptances are logged on
// the falling edge and compared against hand-computed expectations.
module tb_term_sequencer;

  localparam int LW = 4;

  logic          CLK_12MHZ = 1'b0;
  logic          rst;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          i_btn_put;
  logic          i_btn_clear;
  logic          i_busy;
  logic          o_putchar;
  logic          o_clearhome;
  logic [7:0]    o_char;
  logic [LW-1:0] o_level;

  term_sequencer #(.DEPTH(8), .BTN_CHAR(8'h41), .ECHO(1'b1)) dut (
    .CLK_12MHZ     (CLK_12MHZ),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .i_btn_put     (i_btn_put),
    .i_btn_clear   (i_btn_clear),
    .i_busy        (i_busy),
    .o_putchar     (o_putchar),
    .o_clearhome   (o_clearhome),
    .o_char        (o_char),
    .o_level       (o_level)
  );

  always #5 CLK_12MHZ = ~CLK_12MHZ;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse log entry: {is_clearhome, char}; clearhome entries carry char 0
  logic [8:0]  pulse_q[$];
  int          pulse_cyc[$];
  logic [7:0]  echo_q[$];
  int          cyc       = 0;
  int          acc_cnt   = 0;
  int          both_err  = 0;
  bit          send_done = 1'b0;

  always @(posedge CLK_12MHZ) cyc++;

  always @(negedge CLK_12MHZ) begin
    if (o_putchar) begin
      pulse_q.push_back({1'b0, o_char});
      pulse_cyc.push_back(cyc);
    end
    if (o_clearhome) begin
      pulse_q.push_back({1'b1, 8'h00});
      pulse_cyc.push_back(cyc);
    end
    if (o_putchar && o_clearhome) both_err++;
    if (m_axis_tvalid && m_axis_tready) echo_q.push_back(m_axis_tdata);
    if (s_axis_tvalid && s_axis_tready) acc_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_12MHZ);
    #1;
  endtask

  // Offer one byte; returns #1 after the edge that accepted it
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok            = 1'b0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge CLK_12MHZ);
      if (s_axis_tready) ok = 1'b1;
    end
    @(posedge CLK_12MHZ);
    #1;
    s_axis_tvalid = 1'b0;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_range(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) send_byte(first + 8'(i));
    send_done = 1'b1;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    for (int t = 0; t < budget && pulse_q.size() < n; t++) tick(1);
  endtask

  task automatic wait_send(input int budget);
    for (int t = 0; t < budget && !send_done; t++) tick(1);
    check("send_done", 32'(send_done), 32'd1);
  endtask

  typedef struct {
    logic [7:0] din;
    int         exp_n;
    logic [8:0] exp_pulse;
  } vec_t;

  vec_t vecs[9];
  int   acc0;

  initial begin
    vecs[0] = '{8'h41, 1, {1'b0, 8'h41}};
    vecs[1] = '{8'h0C, 1, {1'b1, 8'h00}};
    vecs[2] = '{8'h00, 0, 9'h000};
    vecs[3] = '{8'h7F, 1, {1'b0, 8'h08}};
    vecs[4] = '{8'h08, 1, {1'b0, 8'h08}};
    vecs[5] = '{8'h0A, 1, {1'b0, 8'h0A}};
    vecs[6] = '{8'h0D, 1, {1'b0, 8'h0D}};
    vecs[7] = '{8'hFF, 1, {1'b0, 8'hFF}};
    vecs[8] = '{8'h7E, 1, {1'b0, 8'h7E}};

    rst           = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    i_btn_put     = 1'b0;
    i_btn_clear   = 1'b0;
    i_busy        = 1'b0;

    // Reset state
    tick(3);
    check("reset_outputs",
          32'({s_axis_tready, m_axis_tvalid, m_axis_tdata, o_putchar, o_clearhome, o_char, o_level}),
          32'd0);
    rst = 1'b0;
    tick(1);

    // First byte: pulse two cycles after acceptance, echo one cycle after
    pulse_q.delete();
    send_byte(8'h41);
    check("first_echo_valid", 32'(m_axis_tvalid), 32'd1);
    check("first_echo_data", 32'(m_axis_tdata), 32'h41);
    check("first_no_early_pulse", 32'(o_putchar), 32'd0);
    check("first_level_after_push", 32'(o_level), 32'd1);
    tick(1);
    check("first_putchar", 32'(o_putchar), 32'd1);
    check("first_char", 32'(o_char), 32'h41);
    tick(1);
    check("first_pulse_one_cycle", 32'(o_putchar), 32'd0);
    check("first_level_after_pop", 32'(o_level), 32'd0);
    tick(4);
    check("first_pulse_count", 32'(pulse_q.size()), 32'd1);

    // Character mapping table
    for (int i = 0; i < 9; i++) begin
      pulse_q.delete();
      send_byte(vecs[i].din);
      tick(8);
      check($sformatf("map_%02h_count", vecs[i].din), 32'(pulse_q.size()), 32'(vecs[i].exp_n));
      if (vecs[i].exp_n == 1 && pulse_q.size() == 1)
        check($sformatf("map_%02h_pulse", vecs[i].din), 32'(pulse_q[0]), 32'(vecs[i].exp_pulse));
    end

    // Mapping sequence 0x0C, 0x00, 0x7F back to back
    pulse_q.delete();
    send_byte(8'h0C);
    send_byte(8'h00);
    send_byte(8'h7F);
    tick(20);
    check("mapseq_count", 32'(pulse_q.size()), 32'd2);
    if (pulse_q.size() == 2) begin
      check("mapseq_clear", 32'(pulse_q[0]), 32'h100);
      check("mapseq_del", 32'(pulse_q[1]), 32'h008);
    end

    // Backpressure: first byte issues, then 8 fill the FIFO and the tenth waits
    i_busy = 1'b1;
    pulse_q.delete();
    pulse_cyc.delete();
    acc0      = acc_cnt;
    send_done = 1'b0;
    fork
      send_range(8'h30, 10);
    join_none
    tick(40);
    check("bp_accepted", 32'(acc_cnt - acc0), 32'd9);
    check("bp_tready_low", 32'(s_axis_tready), 32'd0);
    check("bp_level_full", 32'(o_level), 32'd8);
    check("bp_one_issued", 32'(pulse_q.size()), 32'd1);
    i_busy = 1'b0;
    wait_pulses(10, 300);
    wait_send(50);
    check("bp_total_pulses", 32'(pulse_q.size()), 32'd10);
    if (pulse_q.size() == 10) begin
      for (int i = 0; i < 10; i++)
        check($sformatf("bp_order_%0d", i), 32'(pulse_q[i]), 32'({1'b0, 8'h30 + 8'(i)}));
      for (int i = 2; i < 10; i++)
        check($sformatf("bp_spacing_%0d", i), 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd4);
    end
    tick(4);
    check("bp_level_drained", 32'(o_level), 32'd0);

    // Echo stall: one byte held in the echo register blocks further RX
    m_axis_tready = 1'b0;
    pulse_q.delete();
    echo_q.delete();
    acc0      = acc_cnt;
    send_done = 1'b0;
    fork
      send_range(8'h55, 2);
    join_none
    tick(6);
    check("stall_one_accepted", 32'(acc_cnt - acc0), 32'd1);
    check("stall_tready_low", 32'(s_axis_tready), 32'd0);
    check("stall_echo_valid", 32'(m_axis_tvalid), 32'd1);
    check("stall_echo_data", 32'(m_axis_tdata), 32'h55);
    m_axis_tready = 1'b1;
    wait_send(50);
    tick(8);
    check("stall_accepted_total", 32'(acc_cnt - acc0), 32'd2);
    check("stall_echo_count", 32'(echo_q.size()), 32'd2);
    if (echo_q.size() == 2) begin
      check("stall_echo_0", 32'(echo_q[0]), 32'h55);
      check("stall_echo_1", 32'(echo_q[1]), 32'h56);
    end
    check("stall_pulse_count", 32'(pulse_q.size()), 32'd2);

    // Arbitration: clear > FIFO > put, repeated put pulses merge
    i_busy = 1'b1;
    pulse_q.delete();
    send_byte(8'h31);
    tick(2);
    send_byte(8'h42);
    tick(2);
    check("arb_level_queued", 32'(o_level), 32'd1);
    i_btn_put   = 1'b1;
    i_btn_clear = 1'b1;
    tick(1);
    i_btn_put   = 1'b0;
    i_btn_clear = 1'b0;
    tick(2);
    i_btn_put = 1'b1;
    tick(1);
    i_btn_put = 1'b0;
    tick(2);
    i_busy = 1'b0;
    wait_pulses(4, 100);
    tick(12);
    check("arb_pulse_count", 32'(pulse_q.size()), 32'd4);
    if (pulse_q.size() == 4) begin
      check("arb_0_first_byte", 32'(pulse_q[0]), 32'h031);
      check("arb_1_clear", 32'(pulse_q[1]), 32'h100);
      check("arb_2_fifo", 32'(pulse_q[2]), 32'h042);
      check("arb_3_button", 32'(pulse_q[3]), 32'h041);
    end

    // Reset in WAIT with three bytes queued
    i_busy = 1'b1;
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
    send_byte(8'h64);
    tick(2);
    check("rstw_level_before", 32'(o_level), 32'd3);
    rst = 1'b1;
    #1;
    check("rstw_async_outputs",
          32'({s_axis_tready, m_axis_tvalid, m_axis_tdata, o_putchar, o_clearhome, o_char, o_level}),
          32'd0);
    pulse_q.delete();
    tick(2);
    rst    = 1'b0;
    i_busy = 1'b0;
    tick(12);
    check("rstw_no_pulses", 32'(pulse_q.size()), 32'd0);
    check("rstw_level_after", 32'(o_level), 32'd0);
    send_byte(8'h44);
    tick(1);
    check("rstw_idle_putchar", 32'(o_putchar), 32'd1);
    check("rstw_idle_char", 32'(o_char), 32'h44);
    tick(6);

    check("no_double_pulse", 32'(both_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
